reservation_station: RTL and testbench

- Per-functional-unit issue queue directly downstream of the instruction router.
- Accepts one routed, renamed instruction per cycle and holds it until all source PRNs are ready.
- Snoops completion wakeup broadcasts and issues the oldest ready instruction to its functional unit over a valid/ready handshake.

---
 rtl/foxtrot_pkg.sv | 22 ++
 rtl/rs_select.sv | 26 ++
 rtl/reservation_station.sv | 141 ++++++++++++++
 tb/tb_reservation_station.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/foxtrot_pkg.sv
// Shared types and default widths for the reservation station slice.
// The entry struct is sized from these defaults, so the station parameters must match them.
package foxtrot_pkg;

    localparam int RS_INST_ID_BITS = 6;
    localparam int RS_PRN_BITS     = 6;
    localparam int RS_MAX_OPERANDS = 3;
    localparam int RS_QUEUE_SIZE   = 4;
    localparam int RS_WAKEUP_PORTS = 2;

    typedef struct packed {
        logic [RS_INST_ID_BITS-1:0]                    inst_id;
        logic [31:0]                                   raw_instr;
        logic [63:0]                                   instr_pc;
        logic [RS_MAX_OPERANDS-1:0]                    src_valid;
        logic [RS_MAX_OPERANDS-1:0]                    src_rdy;
        logic [RS_MAX_OPERANDS-1:0][RS_PRN_BITS-1:0]   src_prn;
        logic [RS_MAX_OPERANDS-1:0]                    dst_valid;
        logic [RS_MAX_OPERANDS-1:0][RS_PRN_BITS-1:0]   dst_prn;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-first priority encoder: index 0 is the oldest entry and wins ties.
module rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] index,
    output logic                 any_valid
);

    always_comb begin
        grant     = '0;
        index     = '0;
        any_valid = 1'b0;
        // Scan from the youngest down so the lowest requesting index is the last to win
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                index     = ($clog2(N))'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Compacting per-FU issue queue: holds renamed instructions until their sources
// are woken, then issues the oldest ready one over a valid/ready handshake.
module reservation_station
    import foxtrot_pkg::*;
#(
    parameter int INST_ID_BITS = RS_INST_ID_BITS,
    parameter int PRN_BITS     = RS_PRN_BITS,
    parameter int MAX_OPERANDS = RS_MAX_OPERANDS,
    parameter int QUEUE_SIZE   = RS_QUEUE_SIZE,
    parameter int WAKEUP_PORTS = RS_WAKEUP_PORTS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [INST_ID_BITS-1:0]               in_inst_id,
    input  logic [31:0]                           in_raw_instr,
    input  logic [63:0]                           in_instr_pc,
    input  logic [MAX_OPERANDS-1:0]               in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]               in_prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] in_prn_input,
    input  logic [MAX_OPERANDS-1:0]               in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] in_prn_output,
    input  logic [WAKEUP_PORTS-1:0]               wakeup_valid,
    input  logic [WAKEUP_PORTS-1:0][PRN_BITS-1:0] wakeup_prn,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INST_ID_BITS-1:0]               out_inst_id,
    output logic [31:0]                           out_raw_instr,
    output logic [63:0]                           out_instr_pc,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_input,
    output logic [MAX_OPERANDS-1:0]               out_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_output,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]       occupancy
);

    localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
    localparam int IDX_W = $clog2(QUEUE_SIZE);

    rs_entry_t                 entries      [QUEUE_SIZE];
    rs_entry_t                 entries_next [QUEUE_SIZE];
    rs_entry_t                 upper        [QUEUE_SIZE];
    rs_entry_t                 new_entry;
    rs_entry_t                 out_entry;
    rs_entry_t                 shifted;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [CNT_W-1:0]          enq_pos;
    logic [QUEUE_SIZE-1:0]     issuable;
    logic [QUEUE_SIZE-1:0]     grant;
    logic [IDX_W-1:0]          sel_idx;
    logic                      any_issuable;
    logic                      do_issue;
    logic                      do_enq;

    always_comb begin
        issuable = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            issuable[i] = (CNT_W'(i) < count) && (&entries[i].src_rdy);
        end
    end

    rs_select #(.N(QUEUE_SIZE)) u_select (
        .req       (issuable),
        .grant     (grant),
        .index     (sel_idx),
        .any_valid (any_issuable)
    );

    assign in_ready  = (count < CNT_W'(QUEUE_SIZE));
    assign out_valid = any_issuable;
    assign occupancy = count;
    // Flush wins over both handshakes, so neither side may move state that cycle
    assign do_issue  = any_issuable && out_ready && !flush;
    assign do_enq    = in_valid && in_ready && !flush;

    always_comb begin
        out_entry = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (grant[i]) out_entry = entries[i];
        end
    end

    assign out_inst_id          = out_entry.inst_id;
    assign out_raw_instr        = out_entry.raw_instr;
    assign out_instr_pc         = out_entry.instr_pc;
    assign out_prn_input        = out_entry.src_prn;
    assign out_prn_output_valid = out_entry.dst_valid;
    assign out_prn_output       = out_entry.dst_prn;

    always_comb begin
        new_entry           = '0;
        new_entry.inst_id   = in_inst_id;
        new_entry.raw_instr = in_raw_instr;
        new_entry.instr_pc  = in_instr_pc;
        new_entry.src_valid = in_prn_input_valid;
        new_entry.src_prn   = in_prn_input;
        new_entry.dst_valid = in_prn_output_valid;
        new_entry.dst_prn   = in_prn_output;
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            new_entry.src_rdy[s] = !in_prn_input_valid[s] || in_prn_input_ready[s];
            for (int w = 0; w < WAKEUP_PORTS; w++) begin
                if (in_prn_input_valid[s] && wakeup_valid[w] && (wakeup_prn[w] == in_prn_input[s]))
                    new_entry.src_rdy[s] = 1'b1;
            end
        end
    end

    // Shift survivors down past the issued slot, then apply wakeups at their new index
    always_comb begin
        for (int i = 0; i < QUEUE_SIZE - 1; i++) upper[i] = entries[i + 1];
        upper[QUEUE_SIZE-1] = '0;
        shifted = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            shifted = (do_issue && (IDX_W'(i) >= sel_idx)) ? upper[i] : entries[i];
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                for (int w = 0; w < WAKEUP_PORTS; w++) begin
                    if (shifted.src_valid[s] && wakeup_valid[w] && (wakeup_prn[w] == shifted.src_prn[s]))
                        shifted.src_rdy[s] = 1'b1;
                end
            end
            entries_next[i] = shifted;
        end
        enq_pos = do_issue ? (count - CNT_W'(1)) : count;
        if (do_enq) entries_next[IDX_W'(enq_pos)] = new_entry;
        if (flush) count_next = '0;
        else       count_next = count + CNT_W'(do_enq) - CNT_W'(do_issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) entries[i] <= '0;
        end else begin
            count <= count_next;
            for (int i = 0; i < QUEUE_SIZE; i++) entries[i] <= entries_next[i];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station: dispatch, wakeup, ordering,
// full back-pressure, same-cycle enqueue/issue, flush and mid-stream reset.
module tb_reservation_station;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_inst_id;
    logic [31:0]      in_raw_instr;
    logic [63:0]      in_instr_pc;
    logic [2:0]       in_prn_input_valid;
    logic [2:0]       in_prn_input_ready;
    logic [2:0][5:0]  in_prn_input;
    logic [2:0]       in_prn_output_valid;
    logic [2:0][5:0]  in_prn_output;
    logic [1:0]       wakeup_valid;
    logic [1:0][5:0]  wakeup_prn;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_inst_id;
    logic [31:0]      out_raw_instr;
    logic [63:0]      out_instr_pc;
    logic [2:0][5:0]  out_prn_input;
    logic [2:0]       out_prn_output_valid;
    logic [2:0][5:0]  out_prn_output;
    logic [2:0]       occupancy;

    int passed = 0;
    int total  = 0;

    reservation_station dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_inst_id           (in_inst_id),
        .in_raw_instr         (in_raw_instr),
        .in_instr_pc          (in_instr_pc),
        .in_prn_input_valid   (in_prn_input_valid),
        .in_prn_input_ready   (in_prn_input_ready),
        .in_prn_input         (in_prn_input),
        .in_prn_output_valid  (in_prn_output_valid),
        .in_prn_output        (in_prn_output),
        .wakeup_valid         (wakeup_valid),
        .wakeup_prn           (wakeup_prn),
        .flush                (flush),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_inst_id          (out_inst_id),
        .out_raw_instr        (out_raw_instr),
        .out_instr_pc         (out_instr_pc),
        .out_prn_input        (out_prn_input),
        .out_prn_output_valid (out_prn_output_valid),
        .out_prn_output       (out_prn_output),
        .occupancy            (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one dispatch; raw/pc/destination fields are derived from the id
    task automatic applyStimulus(input logic v, input logic [5:0] id, input logic [2:0] sv,
                                 input logic [2:0] sr, input logic [5:0] p0, input logic [5:0] p1);
        in_valid            = v;
        in_inst_id          = id;
        in_raw_instr        = 32'hA5A5_0000 ^ {26'd0, id};
        in_instr_pc         = 64'h1000 + {56'd0, id, 2'b00};
        in_prn_input_valid  = sv;
        in_prn_input_ready  = sr;
        in_prn_input        = {6'd0, p1, p0};
        in_prn_output_valid = 3'b001;
        in_prn_output       = {12'd0, id + 6'd32};
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        wakeup_valid = '0;
        wakeup_prn = '0;
        applyStimulus(1'b0, 6'd0, 3'b000, 3'b000, 6'd0, 6'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_inst_id", 64'(out_inst_id), 64'd0);

        // Single ready dispatch issues one cycle later
        applyStimulus(1'b1, 6'd5, 3'b001, 3'b001, 6'd12, 6'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_out_inst_id", 64'(out_inst_id), 64'd5);
        checkOutput("t1_out_raw_instr", 64'(out_raw_instr), 64'hA5A5_0005);
        checkOutput("t1_out_instr_pc", 64'(out_instr_pc), 64'h1014);
        checkOutput("t1_out_prn_input", 64'(out_prn_input), 64'd12);
        checkOutput("t1_out_prn_output", 64'(out_prn_output), 64'd37);
        checkOutput("t1_out_prn_output_valid", 64'(out_prn_output_valid), 64'd1);
        checkOutput("t1_occupancy", 64'(occupancy), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t1_drained_occupancy", 64'(occupancy), 64'd0);
        checkOutput("t1_drained_out_valid", 64'(out_valid), 64'd0);

        // Younger ready instruction overtakes a waiting older one
        applyStimulus(1'b1, 6'd1, 3'b001, 3'b000, 6'd12, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd2, 3'b011, 3'b011, 6'd3, 6'd4);
        tick();
        in_valid = 1'b0;
        checkOutput("t2_bypass_id", 64'(out_inst_id), 64'd2);
        checkOutput("t2_occupancy", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t2_after_issue_occ", 64'(occupancy), 64'd1);
        checkOutput("t2_waiting_out_valid", 64'(out_valid), 64'd0);
        wakeup_valid = 2'b01;
        wakeup_prn   = {6'd0, 6'd12};
        tick();
        wakeup_valid = '0;
        checkOutput("t2_woken_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_woken_id", 64'(out_inst_id), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t2_drained_occ", 64'(occupancy), 64'd0);

        // Fill to capacity with nothing ready, then try a fifth dispatch
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 6'(10 + k), 3'b001, 3'b000, 6'(40 + k), 6'd0);
            tick();
        end
        checkOutput("t3_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t3_full_occ", 64'(occupancy), 64'd4);
        checkOutput("t3_full_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 6'd14, 3'b000, 3'b000, 6'd0, 6'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("t3_drop_occ", 64'(occupancy), 64'd4);
        out_ready = 1'b1;
        wakeup_valid = 2'b11;
        wakeup_prn   = {6'd41, 6'd40};
        tick();
        checkOutput("t3_first_id", 64'(out_inst_id), 64'd10);
        checkOutput("t3_first_occ", 64'(occupancy), 64'd4);
        wakeup_prn   = {6'd43, 6'd42};
        tick();
        wakeup_valid = '0;
        checkOutput("t3_second_id", 64'(out_inst_id), 64'd11);
        checkOutput("t3_second_occ", 64'(occupancy), 64'd3);
        tick();
        checkOutput("t3_third_id", 64'(out_inst_id), 64'd12);
        tick();
        checkOutput("t3_fourth_id", 64'(out_inst_id), 64'd13);
        checkOutput("t3_fourth_occ", 64'(occupancy), 64'd1);
        tick();
        out_ready = 1'b0;
        checkOutput("t3_drained_occ", 64'(occupancy), 64'd0);
        checkOutput("t3_drained_out_valid", 64'(out_valid), 64'd0);

        // Wakeup in the dispatch cycle makes the entry ready on arrival
        applyStimulus(1'b1, 6'd7, 3'b001, 3'b000, 6'd20, 6'd0);
        wakeup_valid = 2'b10;
        wakeup_prn   = {6'd20, 6'd0};
        tick();
        in_valid = 1'b0;
        wakeup_valid = '0;
        checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_out_inst_id", 64'(out_inst_id), 64'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t4_drained_occ", 64'(occupancy), 64'd0);

        // Issue from the middle while a new instruction enqueues
        applyStimulus(1'b1, 6'd8, 3'b001, 3'b000, 6'd50, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd3, 3'b000, 3'b000, 6'd0, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd6, 3'b001, 3'b000, 6'd51, 6'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("t5_mid_id", 64'(out_inst_id), 64'd3);
        checkOutput("t5_pre_occ", 64'(occupancy), 64'd3);
        applyStimulus(1'b1, 6'd9, 3'b000, 3'b000, 6'd0, 6'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("t5_same_cycle_occ", 64'(occupancy), 64'd3);
        checkOutput("t5_new_tail_id", 64'(out_inst_id), 64'd9);
        wakeup_valid = 2'b01;
        wakeup_prn   = {6'd0, 6'd51};
        tick();
        checkOutput("t5_index1_id", 64'(out_inst_id), 64'd6);
        wakeup_prn   = {6'd0, 6'd50};
        tick();
        wakeup_valid = '0;
        checkOutput("t5_index0_id", 64'(out_inst_id), 64'd8);
        out_ready = 1'b1;
        tick();
        checkOutput("t5_order_second", 64'(out_inst_id), 64'd6);
        tick();
        checkOutput("t5_order_third", 64'(out_inst_id), 64'd9);
        tick();
        out_ready = 1'b0;
        checkOutput("t5_drained_occ", 64'(occupancy), 64'd0);

        // Flush beats a concurrent dispatch
        applyStimulus(1'b1, 6'd20, 3'b001, 3'b000, 6'd55, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd21, 3'b001, 3'b000, 6'd55, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd22, 3'b000, 3'b000, 6'd0, 6'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("t6_flush_occ", 64'(occupancy), 64'd0);
        checkOutput("t6_flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("t6_flush_nothing_written", 64'(out_valid), 64'd0);

        // Reset mid-fill discards everything, including the in-flight dispatch
        applyStimulus(1'b1, 6'd30, 3'b000, 3'b000, 6'd0, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd31, 3'b000, 3'b000, 6'd0, 6'd0);
        tick();
        applyStimulus(1'b1, 6'd32, 3'b000, 3'b000, 6'd0, 6'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("t7_reset_occ", 64'(occupancy), 64'd0);
        checkOutput("t7_reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t7_reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t7_reset_out_inst_id", 64'(out_inst_id), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
